// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared encodings for the Execute-stage multiply/divide unit. The control unit,
// the hazard logic and the MDU itself import this package, so an op code or
// state value means the same thing everywhere.
//   mdu_op_e    : 3-bit MDU op code carried with the E-stage instruction
//   mdu_state_e : scheduler FSM states
//   is_arith_op : true for the ops that occupy the MDU (mult/multu/div/divu)
// -----------------------------------------------------------------------------
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

    // Multi-cycle ops: these are the only ones that set busy and stall D.
    function automatic logic is_arith_op(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd4);
    endfunction

endpackage

// File: rtl/mdu_core.sv
// -----------------------------------------------------------------------------
// mdu_core
// Purely combinational multiply/divide datapath, fed by the operands the
// scheduler latched at issue. The scheduler decides when its outputs are
// committed to HI/LO.
//   op          in   latched MDU op
//   a, b        in   latched rs / rt operands
//   res_hi      out  mult: product[63:32]  div: remainder
//   res_lo      out  mult: product[31:0]   div: quotient
//   div_by_zero out  divide op with b == 0 (result must not be committed)
// -----------------------------------------------------------------------------
module mdu_core
    import mdu_pkg::*;
(
    input  mdu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_by_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        is_div;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] safe_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // Sign-extend to 64 bits so the low 64 bits of the product are exact.
    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide is done on magnitudes with one unsigned divider shared with
    // divu. 0x80000000 negates to itself, which is still its correct magnitude,
    // so 0x80000000 / -1 yields quotient 0x80000000 and remainder 0 naturally.
    assign is_div      = (op == MDU_DIV) || (op == MDU_DIVU);
    assign neg_a       = (op == MDU_DIV) && a[31];
    assign neg_b       = (op == MDU_DIV) && b[31];
    assign mag_a       = neg_a ? -a : a;
    assign mag_b       = neg_b ? -b : b;
    assign safe_b      = (b == 32'd0) ? 32'd1 : mag_b;
    assign q_mag       = mag_a / safe_b;
    assign r_mag       = mag_a % safe_b;
    assign quot        = (neg_a ^ neg_b) ? -q_mag : q_mag;
    assign rem         = neg_a ? -r_mag : r_mag;   // remainder follows dividend
    assign div_by_zero = is_div && (b == 32'd0);

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statement can leave it unassigned (no latch).
    always_comb begin
        res_hi = '0;
        res_lo = '0;
        case (op)
            MDU_MULT:           {res_hi, res_lo} = prod_s;
            MDU_MULTU:          {res_hi, res_lo} = prod_u;
            MDU_DIV, MDU_DIVU: begin
                res_hi = rem;
                res_lo = quot;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_scheduler.sv
// -----------------------------------------------------------------------------
// mdu_scheduler
// Execute-stage MDU controller. Accepts MDU ops from E, runs a fixed-latency
// operation, commits HI/LO at completion and raises the decode-stage stall.
// Owns the architectural HI/LO registers.
//   clk       in   clock, rising edge
//   reset     in   asynchronous, active-low reset
//   e_start   in   E-stage instruction is an MDU op
//   e_op      in   MDU op code (mdu_op_e)
//   e_a, e_b  in   forwarded rs / rt values
//   d_md_use  in   D-stage instruction uses the MDU
//   busy      out  operation in flight
//   stall_d   out  freeze F/D and bubble E
//   hi, lo    out  architectural HI / LO
// -----------------------------------------------------------------------------
module mdu_scheduler
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_start,
    input  logic [2:0]  e_op,
    input  logic [31:0] e_a,
    input  logic [31:0] e_b,
    input  logic        d_md_use,
    output logic        busy,
    output logic        stall_d,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // The counter is loaded with latency-1 and the commit happens on the edge
    // where it reads 0, giving exactly MULT_CYCLES / DIV_CYCLES busy cycles.
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    mdu_state_e       state;
    mdu_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    mdu_op_e          op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;

    mdu_op_e          e_op_t;
    logic             issue;
    logic             move_ok;
    logic             done;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             div_by_zero;

    assign e_op_t  = mdu_op_e'(e_op);
    // e_start while RUN is a protocol violation; gating on IDLE ignores it.
    assign issue   = (state == IDLE) && e_start && is_arith_op(e_op);
    assign move_ok = (state == IDLE) && e_start;
    assign done    = (state == RUN) && (cnt == '0);

    mdu_core u_core (
        .op          (op_q),
        .a           (a_q),
        .b           (b_q),
        .res_hi      (res_hi),
        .res_lo      (res_lo),
        .div_by_zero (div_by_zero)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue) state_nxt = RUN;
            RUN:     if (done)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            op_q <= MDU_NONE;
            a_q  <= '0;
            b_q  <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (issue) begin
                op_q <= e_op_t;
                a_q  <= e_a;
                b_q  <= e_b;
                cnt  <= ((e_op_t == MDU_MULT) || (e_op_t == MDU_MULTU)) ? MULT_LOAD : DIV_LOAD;
            end else if (move_ok && (e_op_t == MDU_MTHI)) begin
                hi_q <= e_a;
            end else if (move_ok && (e_op_t == MDU_MTLO)) begin
                lo_q <= e_a;
            end

            if (state == RUN) begin
                if (done) begin
                    // A zero divisor still costs the full latency but leaves
                    // HI/LO untouched.
                    if (!div_by_zero) begin
                        hi_q <= res_hi;
                        lo_q <= res_lo;
                    end
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    assign busy    = (state == RUN);
    // The issue cycle itself stalls D, before busy has risen.
    assign stall_d = d_md_use & (busy | (e_start & is_arith_op(e_op)));
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_mdu_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mdu_scheduler
// Self-checking bench for mdu_scheduler. The driver issues ops, computes the
// expected HI/LO with plain 64-bit arithmetic and pushes it into a queue; a
// separate monitor pops and compares whenever busy falls (a commit).
// -----------------------------------------------------------------------------
module tb_mdu_scheduler;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        e_start;
    logic [2:0]  e_op;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic        d_md_use;
    logic        busy;
    logic        stall_d;
    logic [31:0] hi;
    logic [31:0] lo;

    mdu_scheduler #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .e_start  (e_start),
        .e_op     (e_op),
        .e_a      (e_a),
        .e_b      (e_b),
        .d_md_use (d_md_use),
        .busy     (busy),
        .stall_d  (stall_d),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int          cycles;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_arith(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd4);
    endfunction

    // Reference model: architectural result from plain wide arithmetic.
    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            inout logic [31:0] mhi, inout logic [31:0] mlo);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd1: begin sp = sa * sb; mhi = sp[63:32]; mlo = sp[31:0]; end
            3'd2: begin up = ua * ub; mhi = up[63:32]; mlo = up[31:0]; end
            3'd3: if (b != 0) begin
                sq = sa / sb;   // 64-bit division truncates toward zero
                sr = sa % sb;
                mhi = sr[31:0];
                mlo = sq[31:0];
            end
            3'd4: if (b != 0) begin
                mhi = a % b;
                mlo = a / b;
            end
            3'd5: mhi = a;
            3'd6: mlo = a;
            default: ;
        endcase
    endtask

    // Called at posedge+1. Issues one op for one cycle; for MDU ops waits for
    // completion (bounded) and checks the stall every busy cycle.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic md_use, input bit inject);
        exp_t e;
        int   n;
        d_md_use = md_use;
        e_start  = 1'b1;
        e_op     = op;
        e_a      = a;
        e_b      = b;
        #1;
        check("stall_issue", {63'd0, stall_d}, {63'd0, md_use & is_arith(op)});
        if (is_arith(op)) begin
            e.old_hi = model_hi;
            e.old_lo = model_lo;
            model_op(op, a, b, model_hi, model_lo);
            e.exp_hi = model_hi;
            e.exp_lo = model_lo;
            e.cycles = (op <= 3'd2) ? MULT_CYCLES : DIV_CYCLES;
            exp_q.push_back(e);
        end else begin
            model_op(op, a, b, model_hi, model_lo);
        end
        @(posedge clk); #1;
        e_start = 1'b0;
        e_op    = 3'd0;
        if (!is_arith(op)) begin
            check("move_hi", {32'd0, hi}, {32'd0, model_hi});
            check("move_lo", {32'd0, lo}, {32'd0, model_lo});
            check("move_busy", {63'd0, busy}, 64'd0);
        end else begin
            n = 0;
            while (busy && n < 40) begin
                check("stall_busy", {63'd0, stall_d}, {63'd0, md_use});
                if (inject && n == 1) begin
                    // Protocol violation: must be ignored while running.
                    e_start = 1'b1;
                    e_op    = 3'($urandom_range(1, 6));
                    e_a     = $urandom;
                    e_b     = $urandom;
                end else begin
                    e_start = 1'b0;
                    e_op    = 3'd0;
                end
                @(posedge clk); #1;
                n++;
            end
            e_start = 1'b0;
            e_op    = 3'd0;
            if (n >= 40) check("busy_timeout", 64'd1, 64'd0);
            check("stall_after", {63'd0, stall_d}, 64'd0);
            check("commit_hi", {32'd0, hi}, {32'd0, model_hi});
            check("commit_lo", {32'd0, lo}, {32'd0, model_lo});
        end
    endtask

    task automatic expect_hilo(input string name, input logic [31:0] h, input logic [31:0] l);
        check({name, "_hi"}, {32'd0, hi}, {32'd0, h});
        check({name, "_lo"}, {32'd0, lo}, {32'd0, l});
    endtask

    // Monitor: counts busy cycles, checks HI/LO hold while busy, and on each
    // commit pops the expected entry.
    int   busy_n    = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            prev_busy = 1'b0;
            busy_n    = 0;
        end else begin
            if (busy) begin
                busy_n++;
                if (exp_q.size() > 0) begin
                    check("hold_hi", {32'd0, hi}, {32'd0, exp_q[0].old_hi});
                    check("hold_lo", {32'd0, lo}, {32'd0, exp_q[0].old_lo});
                end
            end
            if (prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_commit", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_hi", {32'd0, hi}, {32'd0, e.exp_hi});
                    check("sb_lo", {32'd0, lo}, {32'd0, e.exp_lo});
                    check("sb_busy_cycles", 64'(busy_n), 64'(e.cycles));
                end
                busy_n = 0;
            end
            prev_busy = busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b0;
        e_start  = 1'b0;
        e_op     = 3'd0;
        e_a      = '0;
        e_b      = '0;
        d_md_use = 1'b1;
        #12;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_stall", {63'd0, stall_d}, 64'd0);
        expect_hilo("rst", 32'h0, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Directed cases with hand-derived results.
        do_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
        expect_hilo("mult_m1x2", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        expect_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);
        do_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        expect_hilo("div_m7d2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        expect_hilo("div_ovf", 32'h0, 32'h8000_0000);
        do_op(3'd6, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        expect_hilo("mtlo", 32'h0, 32'h1234_5678);
        do_op(3'd4, 32'd5, 32'd0, 1'b1, 1'b0);
        expect_hilo("divu_by0", 32'h0, 32'h1234_5678);
        do_op(3'd5, 32'hCAFE_F00D, 32'd0, 1'b1, 1'b0);
        expect_hilo("mthi", 32'hCAFE_F00D, 32'h1234_5678);
        do_op(3'd7, 32'hDEAD_BEEF, 32'd1, 1'b1, 1'b0);
        expect_hilo("rsvd", 32'hCAFE_F00D, 32'h1234_5678);
        do_op(3'd1, 32'd6, 32'd7, 1'b1, 1'b1);
        expect_hilo("mult_inject", 32'h0, 32'd42);

        // Reset pulse in the third busy cycle of a div.
        d_md_use = 1'b0;
        e_start  = 1'b1;
        e_op     = 3'd3;
        e_a      = 32'd100;
        e_b      = 32'd7;
        @(posedge clk); #1;
        e_start = 1'b0;
        e_op    = 3'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        expect_hilo("midrst", 32'h0, 32'h0);
        exp_q.delete();
        model_hi = '0;
        model_lo = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < DIV_CYCLES + 2; i++) begin
            @(posedge clk); #1;
        end
        check("postrst_busy", {63'd0, busy}, 64'd0);
        expect_hilo("postrst", 32'h0, 32'h0);
        do_op(3'd1, 32'd3, 32'd4, 1'b1, 1'b0);
        expect_hilo("mult_3x4", 32'h0, 32'd12);

        // Randomized back-to-back traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            do_op(op, a, b, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end

        @(posedge clk); #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
